// File: rtl/mem_controller.sv
// Operand memory controller: buffers a store stream into a 2^ADDR_W-word memory,
// then delivers it as operand pairs paced by core_control's condition codes.
module mem_controller #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              mc_clk,
  input  logic              mc_reset,
  input  logic              mc_we,
  input  logic [ADDR_W-1:0] mc_data_address_in,
  input  logic [DATA_W-1:0] mc_data_in,
  input  logic              mc_valid_data,
  input  logic              mc_last_data,
  input  logic [3:0]        mc_data_contition,
  output logic [DATA_W-1:0] mc_opa,
  output logic [DATA_W-1:0] mc_opb,
  output logic              mc_cont_procc,
  output logic              mc_data_done,
  output logic              mc_err
);

  typedef enum logic [2:0] {IDLE, WRITE, ARMED, RD_A, RD_B, PRESENT} state_t;

  localparam logic [3:0]      COND_TRANSFER = 4'b1100;
  localparam logic [3:0]      COND_PROC     = 4'b1111;
  localparam logic [3:0]      COND_DONE     = 4'b1110;
  localparam logic [ADDR_W:0] TWO           = (ADDR_W+1)'(2);

  state_t              state, next_state;
  logic [ADDR_W-1:0]   base, wr_ptr, rd_ptr;
  logic [ADDR_W:0]     count, remaining;
  logic [3:0]          prev_cond;
  logic                armed_first;
  logic [DATA_W-1:0]   rd_q;
  logic [DATA_W-1:0]   mem [2**ADDR_W];

  logic                store_start, wr_en, overflow, start, advance, rd_b_en;
  logic [ADDR_W-1:0]   wr_addr, rd_ptr_b;

  // Stream framing is carried by mc_valid_data alone; the last-word flag needs no handling.
  logic unused_last;
  assign unused_last = mc_last_data;

  always_ff @(posedge mc_clk) begin
    if (mc_reset) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (mc_we)  next_state = WRITE;
      WRITE:   if (!mc_we) next_state = ARMED;
      ARMED:   if (start)  next_state = RD_A;
      RD_A:    next_state = RD_B;
      RD_B:    next_state = PRESENT;
      PRESENT: if (advance) next_state = mc_data_done ? IDLE : RD_A;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: every signal gets a default before the case logic so no latch is inferred.
  always_comb begin
    store_start = (state == IDLE) && mc_we;
    wr_en       = mc_we && mc_valid_data &&
                  ((state == IDLE) || ((state == WRITE) && !count[ADDR_W]));
    overflow    = (state == WRITE) && mc_we && mc_valid_data && count[ADDR_W];
    wr_addr     = (state == IDLE) ? mc_data_address_in : wr_ptr;
    start       = (state == ARMED) && (mc_data_contition == COND_TRANSFER) &&
                  ((prev_cond != COND_TRANSFER) || armed_first);
    advance     = (state == PRESENT) && (mc_data_contition == COND_DONE) &&
                  (prev_cond == COND_PROC);
    rd_b_en     = (state == RD_B) && (remaining >= TWO);
    rd_ptr_b    = rd_ptr + ADDR_W'(1);
  end

  // NOTE: the buffer has no reset; stale contents are never read because count bounds every transfer.
  always_ff @(posedge mc_clk) begin
    if (wr_en && !mc_reset) mem[wr_addr] <= mc_data_in;
    if (state == RD_A)      rd_q <= mem[rd_ptr];
  end

  // NOTE: sequential state uses non-blocking assignments; later assignments in this block take priority.
  always_ff @(posedge mc_clk) begin
    if (mc_reset) begin
      base          <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      remaining     <= '0;
      prev_cond     <= '0;
      armed_first   <= 1'b0;
      mc_opa        <= '0;
      mc_opb        <= '0;
      mc_cont_procc <= 1'b0;
      mc_data_done  <= 1'b0;
      mc_err        <= 1'b0;
    end else begin
      prev_cond     <= mc_data_contition;
      armed_first   <= (next_state == ARMED) && (state != ARMED);
      mc_cont_procc <= (next_state == PRESENT);

      if (store_start) begin
        base         <= mc_data_address_in;
        wr_ptr       <= mc_data_address_in;
        count        <= '0;
        mc_err       <= 1'b0;
        mc_data_done <= 1'b0;
      end
      if (wr_en) begin
        wr_ptr <= wr_addr + ADDR_W'(1);
        count  <= (store_start ? '0 : count) + (ADDR_W+1)'(1);
      end
      if (overflow) mc_err <= 1'b1;

      if (start) begin
        rd_ptr    <= base;
        remaining <= count;
      end
      if (advance && !mc_data_done) begin
        rd_ptr    <= rd_ptr + ADDR_W'(2);
        remaining <= remaining - TWO;
      end

      // An empty session still presents one all-zero pair so core_control can finish.
      if (state == RD_B) begin
        mc_opa       <= (remaining == '0) ? '0 : rd_q;
        mc_opb       <= rd_b_en ? mem[rd_ptr_b] : '0;
        mc_data_done <= (remaining <= TWO);
      end
    end
  end

endmodule

// File: tb/tb_mem_controller.sv
// Randomized bench for mem_controller: a word-level session model predicts every
// presented operand pair, with literal pins on the directed sessions.
module tb_mem_controller;

  logic        mc_clk = 1'b0;
  logic        mc_reset = 1'b1;
  logic        mc_we = 1'b0;
  logic [5:0]  mc_data_address_in = '0;
  logic [31:0] mc_data_in = '0;
  logic        mc_valid_data = 1'b0;
  logic        mc_last_data = 1'b0;
  logic [3:0]  mc_data_contition = '0;
  logic [31:0] mc_opa, mc_opb;
  logic        mc_cont_procc, mc_data_done, mc_err;

  mem_controller #(.DATA_W(32), .ADDR_W(6)) dut (
    .mc_clk             (mc_clk),
    .mc_reset           (mc_reset),
    .mc_we              (mc_we),
    .mc_data_address_in (mc_data_address_in),
    .mc_data_in         (mc_data_in),
    .mc_valid_data      (mc_valid_data),
    .mc_last_data       (mc_last_data),
    .mc_data_contition  (mc_data_contition),
    .mc_opa             (mc_opa),
    .mc_opb             (mc_opb),
    .mc_cont_procc      (mc_cont_procc),
    .mc_data_done       (mc_data_done),
    .mc_err             (mc_err)
  );

  always #5 mc_clk = ~mc_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Session model: memory image by address plus the accepted-word count of the current store.
  logic [31:0] model_mem [64];
  int          s_base  = 0;
  int          s_count = 0;

  bit          chk_en   = 1'b0;
  logic        exp_cont = 1'b0;
  logic        exp_done = 1'b0;
  logic        exp_err  = 1'b0;
  logic [31:0] exp_a    = '0;
  logic [31:0] exp_b    = '0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        done;
  } pair_t;

  pair_t obs[$];
  logic  cont_q = 1'b0;

  function automatic logic [31:0] word_at(input int k);
    if (k >= s_count) return 32'h0;
    return model_mem[(s_base + k) % 64];
  endfunction

  function automatic int n_pairs();
    return (s_count == 0) ? 1 : (s_count + 1) / 2;
  endfunction

  task automatic expect_pair(input int i);
    exp_a    = word_at(2 * i);
    exp_b    = word_at(2 * i + 1);
    exp_done = (i == n_pairs() - 1);
    exp_cont = 1'b1;
  endtask

  always @(negedge mc_clk) begin
    if (chk_en) begin
      check("cont_procc", 32'(mc_cont_procc), 32'(exp_cont));
      check("data_done",  32'(mc_data_done),  32'(exp_done));
      check("err",        32'(mc_err),        32'(exp_err));
      if (exp_cont) begin
        check("opa", mc_opa, exp_a);
        check("opb", mc_opb, exp_b);
      end
      if (mc_cont_procc && !cont_q) obs.push_back('{a: mc_opa, b: mc_opb, done: mc_data_done});
      cont_q = mc_cont_procc;
    end
  end

  task automatic tick();
    @(posedge mc_clk);
    #1;
  endtask

  task automatic store(input logic [5:0] base, input logic [31:0] words[$], input bit preload);
    int sent = 0;
    bit first = 1'b1;
    mc_data_contition = 4'b0000;
    while (first || sent < words.size()) begin
      mc_we              = 1'b1;
      mc_data_address_in = first ? base : 6'($urandom);
      mc_valid_data      = (sent < words.size()) && ($urandom_range(3) != 0);
      mc_data_in         = mc_valid_data ? words[sent] : $urandom;
      mc_last_data       = mc_valid_data && (sent == words.size() - 1);
      tick();
      if (first) begin
        s_base   = int'(base);
        s_count  = 0;
        exp_err  = 1'b0;
        exp_done = 1'b0;
      end
      if (mc_valid_data) begin
        if (s_count < 64) begin
          model_mem[(s_base + s_count) % 64] = mc_data_in;
          s_count++;
        end else begin
          exp_err = 1'b1;
        end
        sent++;
      end
      first = 1'b0;
    end
    mc_we         = 1'b0;
    mc_last_data  = 1'b0;
    mc_valid_data = 1'($urandom_range(1));
    mc_data_in    = $urandom;
    if (preload) mc_data_contition = 4'b1100;
    tick();
    mc_valid_data = 1'b0;
  endtask

  task automatic transfer(input bit preloaded, input int hold);
    int np = n_pairs();
    int span = (hold > 3) ? hold : 3;
    if (!preloaded) begin
      repeat ($urandom_range(2)) begin
        mc_data_contition = 4'b0000;
        tick();
      end
    end
    mc_data_contition = 4'b1100;
    tick();
    tick();
    check("start_gap", 32'(mc_cont_procc), 32'd0);
    tick();
    expect_pair(0);
    check("start_latency", 32'(mc_cont_procc), 32'd1);
    for (int i = 0; i < np; i++) begin
      repeat (1 + $urandom_range(2)) begin
        mc_data_contition = 4'b1111;
        mc_we             = 1'($urandom_range(1));
        mc_valid_data     = mc_we;
        mc_data_in        = $urandom;
        tick();
      end
      mc_we         = 1'b0;
      mc_valid_data = 1'b0;
      for (int j = 0; j < span; j++) begin
        mc_data_contition = (j < hold) ? 4'b1110 : 4'b1100;
        tick();
        if (j == 0) exp_cont = 1'b0;
        if (j == 2 && i < np - 1) begin
          expect_pair(i + 1);
          check("advance_latency", 32'(mc_cont_procc), 32'd1);
        end
      end
    end
  endtask

  task automatic random_words(input int n, output logic [31:0] q[$]);
    q = {};
    for (int k = 0; k < n; k++) q.push_back($urandom);
  endtask

  initial begin
    logic [31:0] wq[$];

    repeat (3) tick();
    check("rst_opa",  mc_opa, 32'h0);
    check("rst_opb",  mc_opb, 32'h0);
    check("rst_cont", 32'(mc_cont_procc), 32'd0);
    check("rst_done", 32'(mc_data_done), 32'd0);
    check("rst_err",  32'(mc_err), 32'd0);
    mc_reset = 1'b0;
    chk_en   = 1'b1;
    tick();

    // Four words at base 0: two pairs, done only with the second.
    obs.delete();
    wq = '{32'h11, 32'h22, 32'h33, 32'h44};
    store(6'h00, wq, 1'b0);
    transfer(1'b0, 1);
    check("t1_pairs", 32'(obs.size()), 32'd2);
    if (obs.size() >= 2) begin
      check("t1_p0_a", obs[0].a, 32'h11);
      check("t1_p0_b", obs[0].b, 32'h22);
      check("t1_p0_done", 32'(obs[0].done), 32'd0);
      check("t1_p1_a", obs[1].a, 32'h33);
      check("t1_p1_b", obs[1].b, 32'h44);
      check("t1_p1_done", 32'(obs[1].done), 32'd1);
    end
    repeat (3) tick();
    check("t1_done_held", 32'(mc_data_done), 32'd1);

    // Three words at base 0x3E: the third wraps to address 0, odd tail pads B with zero.
    obs.delete();
    wq = '{32'hA0, 32'hA1, 32'hA2};
    store(6'h3E, wq, 1'b0);
    transfer(1'b0, 1);
    check("t2_pairs", 32'(obs.size()), 32'd2);
    if (obs.size() >= 2) begin
      check("t2_p0_a", obs[0].a, 32'hA0);
      check("t2_p0_b", obs[0].b, 32'hA1);
      check("t2_p1_a", obs[1].a, 32'hA2);
      check("t2_p1_b", obs[1].b, 32'h0);
      check("t2_p1_done", 32'(obs[1].done), 32'd1);
    end

    // 66 words overflow the buffer: 64 kept, 32 pairs, sticky error.
    obs.delete();
    random_words(66, wq);
    store(6'($urandom), wq, 1'b0);
    check("t3_err_after_store", 32'(mc_err), 32'd1);
    transfer(1'b0, 1);
    check("t3_pairs", 32'(obs.size()), 32'd32);
    check("t3_err_sticky", 32'(mc_err), 32'd1);

    // Hold 1110 for five cycles: one advance per pair.
    obs.delete();
    random_words(6, wq);
    store(6'($urandom), wq, 1'b0);
    check("t4_err_cleared", 32'(mc_err), 32'd0);
    transfer(1'b0, 5);
    check("t4_pairs", 32'(obs.size()), 32'd3);

    // Reset while presenting, then a fresh two-word session.
    random_words(4, wq);
    store(6'($urandom), wq, 1'b0);
    mc_data_contition = 4'b1100;
    repeat (3) tick();
    expect_pair(0);
    mc_data_contition = 4'b1111;
    tick();
    mc_reset = 1'b1;
    tick();
    exp_cont = 1'b0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    check("t5_rst_opa",  mc_opa, 32'h0);
    check("t5_rst_opb",  mc_opb, 32'h0);
    check("t5_rst_cont", 32'(mc_cont_procc), 32'd0);
    mc_reset          = 1'b0;
    mc_data_contition = 4'b0000;
    tick();
    obs.delete();
    wq = '{32'hCAFE0001, 32'hCAFE0002};
    store(6'h10, wq, 1'b0);
    transfer(1'b0, 1);
    check("t5_pairs", 32'(obs.size()), 32'd1);
    if (obs.size() >= 1) begin
      check("t5_a", obs[0].a, 32'hCAFE0001);
      check("t5_b", obs[0].b, 32'hCAFE0002);
      check("t5_done", 32'(obs[0].done), 32'd1);
    end

    // 1100 already present on ARMED entry.
    obs.delete();
    random_words(5, wq);
    store(6'($urandom), wq, 1'b1);
    transfer(1'b1, 1);
    check("t6_pairs", 32'(obs.size()), 32'd3);

    // Empty session presents a single zero pair marked done.
    obs.delete();
    wq = {};
    store(6'($urandom), wq, 1'b0);
    transfer(1'b0, 1);
    check("t7_pairs", 32'(obs.size()), 32'd1);
    if (obs.size() >= 1) begin
      check("t7_a", obs[0].a, 32'h0);
      check("t7_b", obs[0].b, 32'h0);
      check("t7_done", 32'(obs[0].done), 32'd1);
    end

    // Randomized sessions: base, length (including overflow), hold and preload.
    for (int s = 0; s < 10; s++) begin
      bit pre = 1'($urandom_range(1));
      random_words($urandom_range(70), wq);
      obs.delete();
      store(6'($urandom), wq, pre);
      transfer(pre, ($urandom_range(1) != 0) ? 5 : 1);
      check("rand_pairs", 32'(obs.size()), 32'(n_pairs()));
    end

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_controller.md
# mem_controller

Operand memory controller directly downstream of `core_control`. It buffers an incoming data stream into a 64-word memory while `mc_we` is high. It then delivers the buffered words, two at a time, as operand pairs to the processing unit, pacing each transfer with `core_control` through `mc_cont_procc` / `mc_data_done` and the 4-bit data condition code.

## Interface
- `DATA_W`, default 32: width of one data word and of each operand.
- `ADDR_W`, default 6: memory address width; depth is 2^ADDR_W = 64 words.

Ports:
- `mc_clk`  in  1  clock; all logic on rising edge.
- `mc_reset`  in  1  synchronous, active-high reset.
- `mc_we`  in  1  write enable from `core_control`; high for the whole store phase.
- `mc_data_address_in`  in  ADDR_W  store base address; sampled on the first cycle `mc_we` is high.
- `mc_data_in`  in  DATA_W  stream word.
- `mc_valid_data`  in  1  `mc_data_in` is valid this cycle.
- `mc_last_data`  in  1  qualifies the final valid word of the stream.
- `mc_data_contition`  in  4  condition code from `core_control`: 1100 = transfer, 1111 = processing, 1110 = processing done.
- `mc_opa`  out  DATA_W  operand A, held stable while `mc_cont_procc` is high.
- `mc_opb`  out  DATA_W  operand B, held stable while `mc_cont_procc` is high.
- `mc_cont_procc`  out  1  operand pair loaded; processing may start.
- `mc_data_done`  out  1  the loaded pair is the last pair.
- `mc_err`  out  1  memory overflow; sticky.

## Operation
- Memory: 2^ADDR_W x DATA_W, synchronous write, registered read with 1-cycle latency. Contents are not cleared by reset.
- Registers:
  - `base`: ADDR_W bits.
  - `wr_ptr`, `rd_ptr`: ADDR_W bits, wrap modulo 64.
  - `count`: ADDR_W+1 bits, 0..64.
  - `remaining`: ADDR_W+1 bits.
  - `prev_cond`: 4 bits, previous cycle's condition code.
- States: IDLE, WRITE, ARMED, RD_A, RD_B, PRESENT.
- IDLE:
  - When `mc_we`=1: latch `base` and `wr_ptr` from `mc_data_address_in`, set `count`=0, clear `mc_err` and `mc_data_done`, go to WRITE.
  - A word valid in this same cycle is also written.
- WRITE:
  - Each cycle with `mc_we` && `mc_valid_data`: if `count`<64, write `mem[wr_ptr]`, then `wr_ptr`++ and `count`++. Otherwise drop the word and set `mc_err`.
  - Leave for ARMED when `mc_we` falls.
  - `mc_last_data` carries no extra meaning here beyond its valid word being written.
- ARMED:
  - Transfer starts when `mc_data_contition`==1100 and `prev_cond`!=1100, or the code is already 1100 on ARMED entry.
  - On start: `rd_ptr`=`base`, `remaining`=`count`, go to RD_A.
- RD_A: issue read at `rd_ptr`; go to RD_B.
- RD_B:
  - Capture the first word into `mc_opa`.
  - If `remaining`>=2, issue read at `rd_ptr`+1; otherwise force `mc_opb`=0.
  - Go to PRESENT.
- PRESENT entry:
  - Capture `mc_opb` if it was read.
  - Set `mc_cont_procc`=1.
  - Set `mc_data_done` = (`remaining`<=2).
- PRESENT exit: leave on the cycle `mc_data_contition`==1110 and `prev_cond`==1111. On that edge:
  - `mc_cont_procc` stays 1 for that cycle and drops the next cycle.
  - If `mc_data_done`: go to IDLE, with `mc_data_done` held until the next store starts.
  - Else: `rd_ptr`+=2, `remaining`-=2, go to RD_A.
- Odd `count`: the last pair carries `mc_opb`=0.
- `count`=0 at transfer start: present zero operands with `mc_data_done`=1, so `core_control` never deadlocks.
- After an overflow, exactly 64 words are transferred.
- `mc_we` rising in any state other than IDLE is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, `prev_cond`=0000, all pointers and counts 0. Reset mid-operation aborts the current session immediately.
- Write latency: a word accepted in cycle N is readable from cycle N+1.
- Transfer latency: 1100 edge sampled in cycle C → `mc_cont_procc`=1 in cycle C+3.
- Next pair latency: 1110 edge sampled in cycle D → `mc_cont_procc` low at D+1, high again at D+3.
- `mc_cont_procc` and `mc_data_done` are both valid during the 1110 edge cycle. This matches `core_control`'s single-cycle DONE_PROC decision.
- `mc_opa` and `mc_opb` change only in RD_B and on PRESENT entry.
- Simultaneous `mc_we` rising and a valid word in IDLE: the word is stored at `base`.

## Test plan
- Store 4 words (0x11, 0x22, 0x33, 0x44) at base 0x00, then drive 1100 / 1111 / 1110 per pair. Required: pairs (0x11, 0x22) then (0x33, 0x44); `mc_data_done`=1 only with the second pair; state returns to IDLE.
- Store 3 words at base 0x3E. Required: the write wraps to address 0x00; pairs are (w0, w1) then (w2, 0) with `mc_data_done`=1.
- Stream 66 valid words. Required: `mc_err` rises on word 65 and stays high; 32 pairs are delivered; `mc_err` clears on the next store start.
- Hold 1110 for 5 cycles while `core_control` sits in TRANS_DATA. Required: exactly one pair advance; `mc_cont_procc` rises at D+3.
- Assert `mc_reset` while in PRESENT. Required: all outputs 0 on the next cycle; a new 2-word store works normally.
- 1100 present on ARMED entry, with `prev_cond` also 1100. Required: transfer starts; `mc_cont_procc` rises 3 cycles later.
